// File: rtl/fp_align_pkg.sv
// Shared definitions for the floating-point exponent-alignment sequencer.
package fp_align_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 8;
    localparam int SHIFT_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    // OR of the bits that a right shift by amt pushes off the bottom of man.
    function automatic logic lost_bits(input logic [MAN_W_DEF-1:0] man,
                                       input logic [2:0]           amt);
        logic [MAN_W_DEF-1:0] mask;
        mask = (8'd1 << amt) - 8'd1;
        return |(man & mask);
    endfunction

endpackage

// File: rtl/fp_exp_order.sv
// Orders an operand pair by exponent; a tie keeps A as the larger operand.
module fp_exp_order #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 8
) (
    input  logic [EXP_W-1:0] exp_a,
    input  logic [MAN_W-1:0] man_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_b,
    output logic [EXP_W-1:0] exp_big,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_small,
    output logic [EXP_W-1:0] diff,
    output logic             swapped
);

    // Compare exponents and route the larger operand to the big side.
    always_comb begin
        exp_big   = exp_a;
        man_big   = man_a;
        man_small = man_b;
        diff      = exp_a - exp_b;
        swapped   = 1'b0;
        if (exp_b > exp_a) begin
            exp_big   = exp_b;
            man_big   = man_b;
            man_small = man_a;
            diff      = exp_b - exp_a;
            swapped   = 1'b1;
        end else begin
            swapped   = 1'b0;
        end
    end

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent-alignment sequencer: orders a pair, drives the external shifter
// for one cycle, then holds the aligned pair until the adder takes it.
module fp_align_ctrl
    import fp_align_pkg::*;
#(
    parameter int EXP_W     = EXP_W_DEF,
    parameter int MAN_W     = MAN_W_DEF,
    parameter bit STICKY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [MAN_W-1:0] man_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_b,
    output logic [MAN_W-1:0] sh_in,
    output logic [3:0]       sh_amt,
    input  logic [MAN_W-1:0] sh_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_small,
    output logic             sticky,
    output logic             swapped
);

    logic [EXP_W-1:0] ord_exp_big_s;
    logic [MAN_W-1:0] ord_man_big_s;
    logic [MAN_W-1:0] ord_man_small_s;
    logic [EXP_W-1:0] ord_diff_s;
    logic             ord_swapped_s;
    logic             ord_near_s;

    state_t           state_r;
    state_t           state_s;

    logic [EXP_W-1:0] big_exp_r;
    logic [MAN_W-1:0] big_man_r;
    logic [MAN_W-1:0] small_man_r;
    logic [2:0]       amt_r;
    logic             near_r;
    logic             op_swapped_r;
    logic             sticky_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [MAN_W-1:0] sh_in_r;
    logic [3:0]       sh_amt_r;
    logic [EXP_W-1:0] exp_out_r;
    logic [MAN_W-1:0] man_big_r;
    logic [MAN_W-1:0] man_small_r;
    logic             sticky_r;
    logic             swapped_r;

    fp_exp_order #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_order (
        .exp_a     (exp_a),
        .man_a     (man_a),
        .exp_b     (exp_b),
        .man_b     (man_b),
        .exp_big   (ord_exp_big_s),
        .man_big   (ord_man_big_s),
        .man_small (ord_man_small_s),
        .diff      (ord_diff_s),
        .swapped   (ord_swapped_s)
    );

    // Shifts beyond the shifter range bypass it entirely.
    assign ord_near_s = (ord_diff_s <= EXP_W'(SHIFT_MAX));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sticky: bits lost by the shifter, or the whole mantissa when bypassed.
    always_comb begin
        sticky_s = 1'b0;
        if (STICKY_EN == 1'b0) begin
            sticky_s = 1'b0;
        end else if (near_r) begin
            sticky_s = lost_bits(small_man_r, amt_r);
        end else begin
            sticky_s = |small_man_r;
        end
    end

    // Operand capture, shifter drive and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            big_exp_r    <= '0;
            big_man_r    <= '0;
            small_man_r  <= '0;
            amt_r        <= 3'd0;
            near_r       <= 1'b0;
            op_swapped_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            sh_in_r      <= '0;
            sh_amt_r     <= 4'd0;
            exp_out_r    <= '0;
            man_big_r    <= '0;
            man_small_r  <= '0;
            sticky_r     <= 1'b0;
            swapped_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        big_exp_r    <= ord_exp_big_s;
                        big_man_r    <= ord_man_big_s;
                        small_man_r  <= ord_man_small_s;
                        amt_r        <= ord_diff_s[2:0];
                        near_r       <= ord_near_s;
                        op_swapped_r <= ord_swapped_s;
                        in_ready_r   <= 1'b0;
                        if (ord_near_s) begin
                            sh_in_r  <= ord_man_small_s;
                            sh_amt_r <= {1'b0, ord_diff_s[2:0]};
                        end else begin
                            sh_in_r  <= '0;
                            sh_amt_r <= 4'd0;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    exp_out_r   <= big_exp_r;
                    man_big_r   <= big_man_r;
                    swapped_r   <= op_swapped_r;
                    sticky_r    <= sticky_s;
                    if (near_r) begin
                        man_small_r <= sh_out;
                    end else begin
                        man_small_r <= '0;
                    end
                    sh_in_r     <= '0;
                    sh_amt_r    <= 4'd0;
                    out_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    sh_in_r     <= '0;
                    sh_amt_r    <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sh_in     = sh_in_r;
    assign sh_amt    = sh_amt_r;
    assign exp_out   = exp_out_r;
    assign man_big   = man_big_r;
    assign man_small = man_small_r;
    assign sticky    = sticky_r;
    assign swapped   = swapped_r;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl with a behavioural 8-bit right shifter.
module tb_fp_align_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] exp_a;
    logic [7:0] man_a;
    logic [3:0] exp_b;
    logic [7:0] man_b;

    logic       in_ready,  in_ready2;
    logic [7:0] sh_in,     sh_in2;
    logic [3:0] sh_amt,    sh_amt2;
    logic [7:0] sh_out,    sh_out2;
    logic       out_valid, out_valid2;
    logic [3:0] exp_out,   exp_out2;
    logic [7:0] man_big,   man_big2;
    logic [7:0] man_small, man_small2;
    logic       sticky,    sticky2;
    logic       swapped,   swapped2;

    int n_cmp = 0;
    int n_err = 0;

    assign sh_out  = sh_in  >> sh_amt[2:0];
    assign sh_out2 = sh_in2 >> sh_amt2[2:0];

    fp_align_ctrl #(.EXP_W(4), .MAN_W(8), .STICKY_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .man_a(man_a), .exp_b(exp_b), .man_b(man_b),
        .sh_in(sh_in), .sh_amt(sh_amt), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
        .man_big(man_big), .man_small(man_small), .sticky(sticky), .swapped(swapped)
    );

    fp_align_ctrl #(.EXP_W(4), .MAN_W(8), .STICKY_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .exp_a(exp_a), .man_a(man_a), .exp_b(exp_b), .man_b(man_b),
        .sh_in(sh_in2), .sh_amt(sh_amt2), .sh_out(sh_out2),
        .out_valid(out_valid2), .out_ready(out_ready), .exp_out(exp_out2),
        .man_big(man_big2), .man_small(man_small2), .sticky(sticky2), .swapped(swapped2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a pair for one accepting edge; returns at the negedge inside ALIGN.
    task automatic send(input logic [3:0] ea, input logic [7:0] ma,
                        input logic [3:0] eb, input logic [7:0] mb);
        @(negedge clk);
        exp_a = ea; man_a = ma; exp_b = eb; man_b = mb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Complete the HOLD handshake and confirm return to IDLE.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_hs_ov"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hs_ir"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = 4'd0; man_a = 8'h00; exp_b = 4'd0; man_b = 8'h00;
        #12;
        chk("rst_ir",  {31'd0, in_ready},  32'd1);
        chk("rst_ov",  {31'd0, out_valid}, 32'd0);
        chk("rst_shi", {24'd0, sh_in},     32'd0);
        chk("rst_sha", {28'd0, sh_amt},    32'd0);
        chk("rst_ms",  {24'd0, man_small}, 32'd0);
        chk("rst_eo",  {28'd0, exp_out},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: diff 3, A larger
        send(4'd5, 8'hB4, 4'd2, 8'hF3);
        chk("t1_ov_align", {31'd0, out_valid}, 32'd0);
        chk("t1_ir_align", {31'd0, in_ready},  32'd0);
        chk("t1_shi",      {24'd0, sh_in},     32'hF3);
        chk("t1_sha",      {28'd0, sh_amt},    32'd3);
        @(negedge clk);
        chk("t1_ov",  {31'd0, out_valid}, 32'd1);
        chk("t1_eo",  {28'd0, exp_out},   32'd5);
        chk("t1_mb",  {24'd0, man_big},   32'hB4);
        chk("t1_ms",  {24'd0, man_small}, 32'h1E);
        chk("t1_st",  {31'd0, sticky},    32'd1);
        chk("t1_sw",  {31'd0, swapped},   32'd0);
        chk("t1_sha_idle", {28'd0, sh_amt}, 32'd0);
        handshake("t1");

        // 2: diff 8, B larger, shifter bypassed
        send(4'd1, 8'h80, 4'd9, 8'hC0);
        chk("t2_sha_align", {28'd0, sh_amt}, 32'd0);
        chk("t2_shi_align", {24'd0, sh_in},  32'd0);
        @(negedge clk);
        chk("t2_ov",  {31'd0, out_valid}, 32'd1);
        chk("t2_eo",  {28'd0, exp_out},   32'd9);
        chk("t2_mb",  {24'd0, man_big},   32'hC0);
        chk("t2_ms",  {24'd0, man_small}, 32'h00);
        chk("t2_st",  {31'd0, sticky},    32'd1);
        chk("t2_sw",  {31'd0, swapped},   32'd1);
        chk("t2_sha_hold", {28'd0, sh_amt}, 32'd0);
        handshake("t2");

        // 3: equal exponents
        send(4'd7, 8'h91, 4'd7, 8'hA5);
        chk("t3_shi", {24'd0, sh_in},  32'hA5);
        chk("t3_sha", {28'd0, sh_amt}, 32'd0);
        @(negedge clk);
        chk("t3_eo",  {28'd0, exp_out},   32'd7);
        chk("t3_mb",  {24'd0, man_big},   32'h91);
        chk("t3_ms",  {24'd0, man_small}, 32'hA5);
        chk("t3_st",  {31'd0, sticky},    32'd0);
        chk("t3_sw",  {31'd0, swapped},   32'd0);
        handshake("t3");

        // 4: backpressure, with a second pair offered during HOLD
        send(4'd5, 8'hB4, 4'd2, 8'hF3);
        @(negedge clk);
        chk("t4_ov0", {31'd0, out_valid}, 32'd1);
        exp_a = 4'd3; man_a = 8'h40; exp_b = 4'd4; man_b = 8'h81;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_ov_bp", {31'd0, out_valid}, 32'd1);
            chk("t4_ir_bp", {31'd0, in_ready},  32'd0);
            chk("t4_ms_bp", {24'd0, man_small}, 32'h1E);
            chk("t4_eo_bp", {28'd0, exp_out},   32'd5);
            chk("t4_sha_bp", {28'd0, sh_amt},   32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_ov_rel", {31'd0, out_valid}, 32'd0);
        chk("t4_ir_rel", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_ir_acc", {31'd0, in_ready}, 32'd0);
        chk("t4_shi2",   {24'd0, sh_in},    32'h40);
        chk("t4_sha2",   {28'd0, sh_amt},   32'd1);
        @(negedge clk);
        chk("t4_ov2", {31'd0, out_valid}, 32'd1);
        chk("t4_eo2", {28'd0, exp_out},   32'd4);
        chk("t4_mb2", {24'd0, man_big},   32'h81);
        chk("t4_ms2", {24'd0, man_small}, 32'h20);
        chk("t4_st2", {31'd0, sticky},    32'd0);
        chk("t4_sw2", {31'd0, swapped},   32'd1);
        handshake("t4");

        // 5: reset asserted in the middle of ALIGN
        send(4'd6, 8'h0F, 4'd2, 8'h3C);
        rst_n = 1'b0;
        #1;
        chk("t5_ov", {31'd0, out_valid}, 32'd0);
        chk("t5_ir", {31'd0, in_ready},  32'd1);
        chk("t5_sha", {28'd0, sh_amt},   32'd0);
        chk("t5_shi", {24'd0, sh_in},    32'd0);
        @(negedge clk);
        chk("t5_ov_held", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // 6: diff 7, all-ones smaller mantissa; second instance has sticky disabled
        send(4'd9, 8'h22, 4'd2, 8'hFF);
        chk("t6_sha",   {28'd0, sh_amt},    32'd7);
        chk("t6_sha3",  {31'd0, sh_amt[3]}, 32'd0);
        chk("t6_shi",   {24'd0, sh_in},     32'hFF);
        @(negedge clk);
        chk("t6_ov",  {31'd0, out_valid}, 32'd1);
        chk("t6_eo",  {28'd0, exp_out},   32'd9);
        chk("t6_mb",  {24'd0, man_big},   32'h22);
        chk("t6_ms",  {24'd0, man_small}, 32'h01);
        chk("t6_st",  {31'd0, sticky},    32'd1);
        chk("t6_sw",  {31'd0, swapped},   32'd0);
        chk("t6_ns_ov", {31'd0, out_valid2}, 32'd1);
        chk("t6_ns_ir", {31'd0, in_ready2},  32'd0);
        chk("t6_ns_eo", {28'd0, exp_out2},   32'd9);
        chk("t6_ns_mb", {24'd0, man_big2},   32'h22);
        chk("t6_ns_ms", {24'd0, man_small2}, 32'h01);
        chk("t6_ns_st", {31'd0, sticky2},    32'd0);
        chk("t6_ns_sw", {31'd0, swapped2},   32'd0);
        handshake("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
